// File: rtl/adaptive_bg_hysteresis_pkg.sv
// Shared definitions for the adaptive background subtractor: mode encodings,
// luma weights, background-word field layout and channel arithmetic helpers.
package adaptive_bg_hysteresis_pkg;

  // Frame processing modes, selected per frame on the frame_start pixel
  typedef enum logic [1:0] {
    MODE_ADAPT  = 2'b00,
    MODE_LOAD   = 2'b01,
    MODE_FREEZE = 2'b10,
    MODE_BYPASS = 2'b11
  } bg_mode_e;

  // BT.601-style luma weights; they sum to 256 so the result fits 8 bits
  localparam int LUMA_COEF_R = 77;
  localparam int LUMA_COEF_G = 150;
  localparam int LUMA_COEF_B = 29;
  localparam int LUMA_SHIFT  = 8;

  // Background word layout, LSB first: {age, prev_fg, bg_pixel}
  localparam int BG_PIXEL_LSB = 0;

  function automatic int bg_prev_fg_bit(input int pixel_width);
    return pixel_width;
  endfunction

  function automatic int bg_age_lsb(input int pixel_width);
    return pixel_width + 1;
  endfunction

  // Widen a raw channel (right-aligned in 'raw') to 8 bits with zero fill
  function automatic logic [7:0] expand_channel(input logic [7:0] raw, input int bits);
    return raw << (8 - bits);
  endfunction

  // Move an 8-bit background channel toward the live value by diff/2^shift,
  // arithmetic shift (rounds toward minus infinity), clamped to 0..255
  function automatic logic [7:0] adapt_channel(input logic [7:0] bg8,
                                               input logic [7:0] live8,
                                               input int shift);
    logic signed [9:0] delta;
    logic signed [9:0] sum;
    delta = $signed({2'b00, live8}) - $signed({2'b00, bg8});
    delta = delta >>> shift;
    sum   = $signed({2'b00, bg8}) + delta;
    if (sum < 10'sd0) return 8'd0;
    if (sum > 10'sd255) return 8'hFF;
    return sum[7:0];
  endfunction

endpackage

// File: rtl/adaptive_bg_hysteresis_rgb_to_luma.sv
// Combinational packed-RGB to 8-bit luma converter.
module rgb_to_luma
  import adaptive_bg_hysteresis_pkg::*;
#(
  parameter int R_BITS = 5,
  parameter int G_BITS = 6,
  parameter int B_BITS = 5,
  localparam int PIXEL_WIDTH = R_BITS + G_BITS + B_BITS
) (
  input  logic [PIXEL_WIDTH-1:0] pixel,
  output logic [7:0]             luma
);

  logic [7:0]  r8, g8, b8;
  logic [15:0] weighted;

  // Expand each channel to 8 bits, then take the weighted sum scaled by 1/256
  always_comb begin
    r8 = expand_channel(8'(pixel[G_BITS+B_BITS +: R_BITS]), R_BITS);
    g8 = expand_channel(8'(pixel[B_BITS +: G_BITS]), G_BITS);
    b8 = expand_channel(8'(pixel[0 +: B_BITS]), B_BITS);
    weighted = 16'(LUMA_COEF_R) * 16'(r8)
             + 16'(LUMA_COEF_G) * 16'(g8)
             + 16'(LUMA_COEF_B) * 16'(b8);
    luma = 8'(weighted >> LUMA_SHIFT);
  end

endmodule

// File: rtl/adaptive_bg_hysteresis.sv
// Adaptive background subtraction with luma hysteresis, ghost absorption
// and a per-frame foreground pixel count. Four-stage pipeline:
//   S1 capture, S2 luma/diff, S3 decision/adaptation, S4 registered outputs.
module adaptive_bg_hysteresis
  import adaptive_bg_hysteresis_pkg::*;
#(
  parameter int ADDR_WIDTH   = 17,
  parameter int R_BITS       = 5,
  parameter int G_BITS       = 6,
  parameter int B_BITS       = 5,
  parameter int SHIFT_LG2    = 3,
  parameter int FG_SHIFT_LG2 = 7,
  parameter int AGE_BITS     = 4,
  localparam int PIXEL_WIDTH = R_BITS + G_BITS + B_BITS,
  localparam int BG_WIDTH    = PIXEL_WIDTH + AGE_BITS + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   in_valid,
  input  logic                   frame_start,
  input  logic [ADDR_WIDTH-1:0]  addr_in,
  input  logic [PIXEL_WIDTH-1:0] live_pixel_in,
  input  logic [BG_WIDTH-1:0]    bg_word_in,
  input  logic [1:0]             mode_in,
  input  logic [8:0]             thresh_hi,
  input  logic [8:0]             thresh_lo,
  input  logic [AGE_BITS-1:0]    age_limit,
  output logic                   bg_wr_en,
  output logic [ADDR_WIDTH-1:0]  bg_wr_addr,
  output logic [BG_WIDTH-1:0]    bg_wr_data,
  output logic                   out_valid,
  output logic [PIXEL_WIDTH-1:0] fg_pixel_out,
  output logic                   foreground_flag,
  output logic [ADDR_WIDTH-1:0]  fg_count,
  output logic                   fg_count_valid
);

  localparam int PREV_FG_BIT = bg_prev_fg_bit(PIXEL_WIDTH);
  localparam int AGE_LSB     = bg_age_lsb(PIXEL_WIDTH);
  localparam int R_LSB       = G_BITS + B_BITS;
  localparam int G_LSB       = B_BITS;

  // ---------------- Stage 1: capture ----------------
  bg_mode_e               frame_mode, pixel_mode;
  logic                   s1_valid, s1_fs;
  logic [ADDR_WIDTH-1:0]  s1_addr;
  logic [PIXEL_WIDTH-1:0] s1_live;
  logic [BG_WIDTH-1:0]    s1_bg;
  bg_mode_e               s1_mode;

  // A valid frame_start pixel already runs in the newly requested mode
  always_comb begin
    pixel_mode = frame_mode;
    if (in_valid && frame_start) pixel_mode = bg_mode_e'(mode_in);
  end

  // Capture the incoming pixel and hold the frame mode between frame starts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_mode <= MODE_ADAPT;
      s1_valid   <= 1'b0;
      s1_fs      <= 1'b0;
      s1_addr    <= '0;
      s1_live    <= '0;
      s1_bg      <= '0;
      s1_mode    <= MODE_ADAPT;
    end else if (enable) begin
      frame_mode <= pixel_mode;
      s1_valid   <= in_valid;
      s1_fs      <= in_valid & frame_start;
      s1_addr    <= addr_in;
      s1_live    <= live_pixel_in;
      s1_bg      <= bg_word_in;
      s1_mode    <= pixel_mode;
    end
  end

  // ---------------- Stage 2: luma difference ----------------
  logic [7:0]             luma_live, luma_bg;
  logic [8:0]             luma_diff;
  logic                   s2_valid, s2_fs;
  logic [ADDR_WIDTH-1:0]  s2_addr;
  logic [PIXEL_WIDTH-1:0] s2_live;
  logic [BG_WIDTH-1:0]    s2_bg;
  bg_mode_e               s2_mode;
  logic [8:0]             s2_diff;

  rgb_to_luma #(.R_BITS(R_BITS), .G_BITS(G_BITS), .B_BITS(B_BITS)) u_luma_live (
    .pixel (s1_live),
    .luma  (luma_live)
  );

  rgb_to_luma #(.R_BITS(R_BITS), .G_BITS(G_BITS), .B_BITS(B_BITS)) u_luma_bg (
    .pixel (s1_bg[PIXEL_WIDTH-1:0]),
    .luma  (luma_bg)
  );

  // Absolute luma distance between the live and stored background pixel
  always_comb begin
    if (luma_live >= luma_bg) luma_diff = {1'b0, luma_live - luma_bg};
    else                      luma_diff = {1'b0, luma_bg - luma_live};
  end

  // Register the difference alongside the pixel context
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_fs    <= 1'b0;
      s2_addr  <= '0;
      s2_live  <= '0;
      s2_bg    <= '0;
      s2_mode  <= MODE_ADAPT;
      s2_diff  <= '0;
    end else if (enable) begin
      s2_valid <= s1_valid;
      s2_fs    <= s1_fs;
      s2_addr  <= s1_addr;
      s2_live  <= s1_live;
      s2_bg    <= s1_bg;
      s2_mode  <= s1_mode;
      s2_diff  <= luma_diff;
    end
  end

  // ---------------- Stage 3: decision and adaptation ----------------
  logic                   prev_fg, fg_raw, absorb;
  logic [AGE_BITS-1:0]    stored_age, age_next;
  int                     adapt_shift;
  logic [7:0]             live_r8, live_g8, live_b8;
  logic [7:0]             bg_r8, bg_g8, bg_b8;
  logic [7:0]             new_r8, new_g8, new_b8;
  logic [PIXEL_WIDTH-1:0] adapted_pixel;

  logic                   s3_valid, s3_fs, s3_fg, s3_absorb;
  logic [ADDR_WIDTH-1:0]  s3_addr;
  logic [PIXEL_WIDTH-1:0] s3_live, s3_adapted;
  logic [AGE_BITS-1:0]    s3_age;
  bg_mode_e               s3_mode;

  // Hysteresis threshold, age tracking, ghost absorption and per-channel
  // background drift (slower while the pixel is considered foreground)
  always_comb begin
    prev_fg    = s2_bg[PREV_FG_BIT];
    stored_age = s2_bg[AGE_LSB +: AGE_BITS];
    fg_raw     = prev_fg ? (s2_diff > thresh_lo) : (s2_diff > thresh_hi);
    if (!fg_raw)                                 age_next = '0;
    else if (stored_age == {AGE_BITS{1'b1}})     age_next = stored_age;
    else                                         age_next = stored_age + 1'b1;
    absorb      = fg_raw && (age_limit != '0) && (age_next >= age_limit);
    adapt_shift = fg_raw ? FG_SHIFT_LG2 : SHIFT_LG2;
    live_r8 = expand_channel(8'(s2_live[R_LSB +: R_BITS]), R_BITS);
    live_g8 = expand_channel(8'(s2_live[G_LSB +: G_BITS]), G_BITS);
    live_b8 = expand_channel(8'(s2_live[0 +: B_BITS]), B_BITS);
    bg_r8   = expand_channel(8'(s2_bg[R_LSB +: R_BITS]), R_BITS);
    bg_g8   = expand_channel(8'(s2_bg[G_LSB +: G_BITS]), G_BITS);
    bg_b8   = expand_channel(8'(s2_bg[0 +: B_BITS]), B_BITS);
    new_r8  = adapt_channel(bg_r8, live_r8, adapt_shift);
    new_g8  = adapt_channel(bg_g8, live_g8, adapt_shift);
    new_b8  = adapt_channel(bg_b8, live_b8, adapt_shift);
    adapted_pixel = {R_BITS'(new_r8 >> (8 - R_BITS)),
                     G_BITS'(new_g8 >> (8 - G_BITS)),
                     B_BITS'(new_b8 >> (8 - B_BITS))};
  end

  // Register the per-pixel decision and candidate background word fields
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_valid   <= 1'b0;
      s3_fs      <= 1'b0;
      s3_fg      <= 1'b0;
      s3_absorb  <= 1'b0;
      s3_addr    <= '0;
      s3_live    <= '0;
      s3_adapted <= '0;
      s3_age     <= '0;
      s3_mode    <= MODE_ADAPT;
    end else if (enable) begin
      s3_valid   <= s2_valid;
      s3_fs      <= s2_fs;
      s3_fg      <= fg_raw;
      s3_absorb  <= absorb;
      s3_addr    <= s2_addr;
      s3_live    <= s2_live;
      s3_adapted <= adapted_pixel;
      s3_age     <= age_next;
      s3_mode    <= s2_mode;
    end
  end

  // ---------------- Stage 4: outputs ----------------
  logic                   flag_next, wr_en_next;
  logic [BG_WIDTH-1:0]    wr_data_next;
  logic [PIXEL_WIDTH-1:0] pix_next;
  logic [ADDR_WIDTH-1:0]  fg_counter;
  logic                   first_frame;

  // Mode-dependent flag, write strobe, write word and output pixel
  always_comb begin
    flag_next = 1'b0;
    if (s3_valid && (s3_mode == MODE_ADAPT || s3_mode == MODE_FREEZE))
      flag_next = s3_fg & ~s3_absorb;
    wr_en_next = s3_valid && (s3_mode == MODE_ADAPT || s3_mode == MODE_LOAD);
    if (s3_mode == MODE_LOAD || s3_absorb)
      wr_data_next = {{AGE_BITS{1'b0}}, 1'b0, s3_live};
    else
      wr_data_next = {s3_age, s3_fg, s3_adapted};
    pix_next = '0;
    if (s3_valid && (s3_mode == MODE_BYPASS || flag_next)) pix_next = s3_live;
  end

  // Output registers; strobes drop while stalled so nothing is seen twice
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid       <= 1'b0;
      bg_wr_en        <= 1'b0;
      bg_wr_addr      <= '0;
      bg_wr_data      <= '0;
      foreground_flag <= 1'b0;
      fg_pixel_out    <= '0;
    end else if (enable) begin
      out_valid       <= s3_valid;
      bg_wr_en        <= wr_en_next;
      bg_wr_addr      <= s3_addr;
      bg_wr_data      <= wr_data_next;
      foreground_flag <= flag_next;
      fg_pixel_out    <= pix_next;
    end else begin
      out_valid       <= 1'b0;
      bg_wr_en        <= 1'b0;
    end
  end

  // Saturating per-frame foreground counter, published at each frame start
  // except the first one after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fg_counter     <= '0;
      fg_count       <= '0;
      fg_count_valid <= 1'b0;
      first_frame    <= 1'b1;
    end else if (enable) begin
      fg_count_valid <= 1'b0;
      if (s3_valid && s3_fs) begin
        if (first_frame) begin
          first_frame <= 1'b0;
        end else begin
          fg_count       <= fg_counter;
          fg_count_valid <= 1'b1;
        end
        fg_counter <= flag_next ? ADDR_WIDTH'(1) : '0;
      end else if (flag_next && fg_counter != {ADDR_WIDTH{1'b1}}) begin
        fg_counter <= fg_counter + 1'b1;
      end
    end else begin
      fg_count_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adaptive_bg_hysteresis.sv
// Scoreboard testbench for adaptive_bg_hysteresis with hand-computed vectors.
module tb_adaptive_bg_hysteresis;
  import adaptive_bg_hysteresis_pkg::*;

  localparam int AW = 17;
  localparam int PW = 16;
  localparam int BW = 21;

  logic          clk = 1'b0;
  logic          rst_n, enable, in_valid, frame_start;
  logic [AW-1:0] addr_in;
  logic [PW-1:0] live_pixel_in;
  logic [BW-1:0] bg_word_in;
  logic [1:0]    mode_in;
  logic [8:0]    thresh_hi, thresh_lo;
  logic [3:0]    age_limit;
  logic          bg_wr_en, out_valid, foreground_flag, fg_count_valid;
  logic [AW-1:0] bg_wr_addr, fg_count;
  logic [BW-1:0] bg_wr_data;
  logic [PW-1:0] fg_pixel_out;

  typedef struct packed {
    logic          wr_en;
    logic [AW-1:0] addr;
    logic [BW-1:0] data;
    logic          flag;
    logic [PW-1:0] pix;
  } exp_t;

  exp_t          exp_q[$];
  logic [AW-1:0] cnt_q[$];
  int            checks = 0;
  int            passes = 0;
  int            tally;
  bit            first_frame;
  bit            rand_en;

  adaptive_bg_hysteresis dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid),
    .frame_start(frame_start), .addr_in(addr_in), .live_pixel_in(live_pixel_in),
    .bg_word_in(bg_word_in), .mode_in(mode_in), .thresh_hi(thresh_hi),
    .thresh_lo(thresh_lo), .age_limit(age_limit), .bg_wr_en(bg_wr_en),
    .bg_wr_addr(bg_wr_addr), .bg_wr_data(bg_wr_data), .out_valid(out_valid),
    .fg_pixel_out(fg_pixel_out), .foreground_flag(foreground_flag),
    .fg_count(fg_count), .fg_count_valid(fg_count_valid)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
    checks++;
    if (actual === required) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, required);
  endtask

  // Drive one pixel until an enabled edge consumes it; queue its expected output
  task automatic applyStimulus(input bit fs, input logic [AW-1:0] addr, input logic [PW-1:0] live,
                               input logic [BW-1:0] bgw, input logic [1:0] mode,
                               input bit exp_we, input logic [BW-1:0] exp_data,
                               input bit exp_flag, input logic [PW-1:0] exp_pix);
    exp_t e;
    bit   taken;
    if (fs) begin
      if (!first_frame) cnt_q.push_back(AW'(tally));
      first_frame = 1'b0;
      tally = 0;
    end
    if (exp_flag) tally++;
    e.wr_en = exp_we;
    e.addr  = addr;
    e.data  = exp_data;
    e.flag  = exp_flag;
    e.pix   = exp_pix;
    exp_q.push_back(e);
    taken = 1'b0;
    while (!taken) begin
      @(negedge clk);
      in_valid      = 1'b1;
      frame_start   = fs;
      addr_in       = addr;
      live_pixel_in = live;
      bg_word_in    = bgw;
      mode_in       = mode;
      enable        = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk);
      taken = enable;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid    = 1'b0;
      frame_start = 1'b0;
      enable      = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  // Let the pipeline empty (bounded) and confirm every expected response appeared
  task automatic drain();
    int n;
    n = 0;
    rand_en = 1'b0;
    while ((exp_q.size() != 0 || cnt_q.size() != 0) && n < 200) begin
      idle(1);
      n++;
    end
    idle(2);
    checkOutput("pending_outputs", 64'(exp_q.size()), 64'd0);
    checkOutput("pending_counts", 64'(cnt_q.size()), 64'd0);
  endtask

  task automatic resetChecks(input string tag);
    checkOutput({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    checkOutput({tag, "_bg_wr_en"}, 64'(bg_wr_en), 64'd0);
    checkOutput({tag, "_bg_wr_addr"}, 64'(bg_wr_addr), 64'd0);
    checkOutput({tag, "_bg_wr_data"}, 64'(bg_wr_data), 64'd0);
    checkOutput({tag, "_flag"}, 64'(foreground_flag), 64'd0);
    checkOutput({tag, "_fg_pixel"}, 64'(fg_pixel_out), 64'd0);
    checkOutput({tag, "_fg_count"}, 64'(fg_count), 64'd0);
    checkOutput({tag, "_fg_count_valid"}, 64'(fg_count_valid), 64'd0);
  endtask

  // Monitor: pop and compare whenever the DUT presents a pixel or a count
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_out_valid", 64'(out_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("bg_wr_en", 64'(bg_wr_en), 64'(e.wr_en));
          checkOutput("bg_wr_addr", 64'(bg_wr_addr), 64'(e.addr));
          if (e.wr_en) checkOutput("bg_wr_data", 64'(bg_wr_data), 64'(e.data));
          checkOutput("foreground_flag", 64'(foreground_flag), 64'(e.flag));
          checkOutput("fg_pixel_out", 64'(fg_pixel_out), 64'(e.pix));
        end
      end else if (bg_wr_en) begin
        checkOutput("wr_en_without_valid", 64'(bg_wr_en), 64'd0);
      end
      if (fg_count_valid) begin
        if (cnt_q.size() == 0) checkOutput("unexpected_fg_count_valid", 64'(fg_count_valid), 64'd0);
        else checkOutput("fg_count", 64'(fg_count), 64'(cnt_q.pop_front()));
      end
    end
  end

  // Watchdog
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; enable = 1'b1; in_valid = 1'b0; frame_start = 1'b0;
    addr_in = '0; live_pixel_in = '0; bg_word_in = '0; mode_in = 2'b00;
    thresh_hi = 9'd255; thresh_lo = 9'd255; age_limit = 4'd0;
    first_frame = 1'b1; tally = 0; rand_en = 1'b0;
    repeat (3) @(negedge clk);
    resetChecks("reset");
    rst_n = 1'b1;
    $display("[TB] LOAD frame");
    for (int i = 0; i < 4; i++)
      applyStimulus(i == 0, AW'(i), 16'hFFFF, 21'h1FFFF, MODE_LOAD, 1, 21'h00FFFF, 0, 16'h0000);
    drain();

    $display("[TB] ADAPT drift, no foreground");
    thresh_hi = 9'd255; thresh_lo = 9'd255;
    applyStimulus(1, 17'd10, 16'hFFFF, 21'h000000, MODE_ADAPT, 1, 21'h0018E3, 0, 16'h0000);
    applyStimulus(0, 17'd11, 16'h0000, 21'h00FFFF, MODE_ADAPT, 1, 21'h00DEFB, 0, 16'h0000);
    drain();

    $display("[TB] hysteresis");
    thresh_hi = 9'd40; thresh_lo = 9'd10;
    applyStimulus(1, 17'd20, 16'h0102, 21'h000000, MODE_ADAPT, 1, 21'h000020, 0, 16'h0000);
    applyStimulus(0, 17'd21, 16'h0102, 21'h010000, MODE_ADAPT, 1, 21'h030000, 1, 16'h0102);
    applyStimulus(1, 17'd22, 16'h0102, 21'h010000, MODE_FREEZE, 0, 21'h000000, 1, 16'h0102);
    applyStimulus(0, 17'd23, 16'h0102, 21'h000000, MODE_FREEZE, 0, 21'h000000, 0, 16'h0000);
    applyStimulus(1, 17'd30, 16'h1234, 21'h01FFFF, MODE_BYPASS, 0, 21'h000000, 0, 16'h1234);
    drain();

    $display("[TB] ghost absorption");
    thresh_hi = 9'd100; thresh_lo = 9'd10; age_limit = 4'd3;
    applyStimulus(1, 17'd40, 16'hFFFF, 21'h000000, MODE_ADAPT, 1, 21'h030000, 1, 16'hFFFF);
    applyStimulus(1, 17'd40, 16'hFFFF, 21'h030000, MODE_ADAPT, 1, 21'h050000, 1, 16'hFFFF);
    applyStimulus(1, 17'd40, 16'hFFFF, 21'h050000, MODE_ADAPT, 1, 21'h00FFFF, 0, 16'h0000);
    drain();

    $display("[TB] frame foreground count");
    age_limit = 4'd0;
    for (int i = 0; i < 100; i++) begin
      if (i < 37) applyStimulus(i == 0, AW'(100 + i), 16'hFFFF, 21'h000000, MODE_ADAPT, 1, 21'h030000, 1, 16'hFFFF);
      else        applyStimulus(i == 0, AW'(100 + i), 16'h0000, 21'h000000, MODE_ADAPT, 1, 21'h000000, 0, 16'h0000);
    end
    applyStimulus(1, 17'd300, 16'h0000, 21'h000000, MODE_ADAPT, 1, 21'h000000, 0, 16'h0000);
    drain();

    $display("[TB] reset mid-frame");
    applyStimulus(1, 17'd70, 16'hFFFF, 21'h000000, MODE_ADAPT, 1, 21'h030000, 1, 16'hFFFF);
    idle(6);
    applyStimulus(0, 17'd71, 16'hFFFF, 21'h000000, MODE_ADAPT, 1, 21'h030000, 1, 16'hFFFF);
    applyStimulus(0, 17'd72, 16'hFFFF, 21'h000000, MODE_ADAPT, 1, 21'h030000, 1, 16'hFFFF);
    @(negedge clk);
    in_valid = 1'b0; frame_start = 1'b0;
    rst_n = 1'b0;
    exp_q.delete(); cnt_q.delete();
    first_frame = 1'b1; tally = 0;
    repeat (3) @(negedge clk);
    resetChecks("midreset");
    rst_n = 1'b1;

    $display("[TB] random enable after reset");
    rand_en = 1'b1;
    applyStimulus(1, 17'd50, 16'hFFFF, 21'h000000, MODE_ADAPT, 1, 21'h030000, 1, 16'hFFFF);
    applyStimulus(0, 17'd51, 16'h0102, 21'h010000, MODE_ADAPT, 1, 21'h030000, 1, 16'h0102);
    idle(3);
    applyStimulus(0, 17'd52, 16'h0102, 21'h000000, MODE_ADAPT, 1, 21'h000020, 0, 16'h0000);
    applyStimulus(0, 17'd53, 16'h0000, 21'h00FFFF, MODE_ADAPT, 1, 21'h03F7DE, 1, 16'h0000);
    applyStimulus(1, 17'd60, 16'hFFFF, 21'h000000, MODE_LOAD, 1, 21'h00FFFF, 0, 16'h0000);
    applyStimulus(0, 17'd61, 16'hFFFF, 21'h050000, MODE_LOAD, 1, 21'h00FFFF, 0, 16'h0000);
    applyStimulus(1, 17'd62, 16'h0000, 21'h000000, MODE_ADAPT, 1, 21'h000000, 0, 16'h0000);
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
